// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// The arbiter uses the master view; requesters and the memory model use the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport master (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_ack, if_rdata, if_stall,
    output d_ack, d_rdata, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output owner, busy
  );

  modport slave (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_ack, if_rdata, if_stall,
    input  d_ack, d_rdata, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  owner, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// at a time, with a streak counter that keeps data traffic from starving fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.master  bus_io
);
  localparam int          STRB_W    = DATA_W / 8;
  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              killed_q;
  logic [3:0]        streak_q;
  logic [3:0]        streak_d;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;

  logic              fetchForced;
  logic              grantData;
  logic              anyReq;
  logic              killHit;
  logic              respDone;
  logic              ifAck;
  logic              dAck;

  assign anyReq      = bus_io.if_req || bus_io.d_req;
  assign fetchForced = bus_io.if_req && bus_io.d_req && (streak_q == LIMIT);
  assign grantData   = bus_io.d_req && !fetchForced;
  assign killHit     = bus_io.if_kill && !owner_q;

  // Only contested data grants count toward the streak; uncontested ones leave it alone.
  always_comb begin
    streak_d = streak_q;
    if (grantData) begin
      if (bus_io.if_req && (streak_q != LIMIT)) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (bus_io.if_req) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      killed_q    <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            streak_q  <= streak_d;
            if (grantData) begin
              owner_q     <= 1'b1;
              mem_we_q    <= bus_io.d_we;
              mem_addr_q  <= bus_io.d_addr;
              mem_wdata_q <= bus_io.d_wdata;
              mem_wstrb_q <= bus_io.d_wstrb;
            end else begin
              owner_q     <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus_io.if_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
          end
        end
        REQ: begin
          if (killHit) begin
            killed_q <= 1'b1;
          end
          if (bus_io.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (killHit) begin
            killed_q <= 1'b1;
          end
          if (bus_io.mem_rvalid) begin
            state_q  <= IDLE;
            killed_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          killed_q  <= 1'b0;
        end
      endcase
    end
  end

  // A kill arriving in the same cycle as the response must still swallow the fetch ack.
  assign respDone = (state_q == RESP) && bus_io.mem_rvalid;
  assign ifAck    = respDone && !owner_q && !killed_q && !bus_io.if_kill;
  assign dAck     = respDone && owner_q;

  assign bus_io.if_ack    = ifAck;
  assign bus_io.if_rdata  = ifAck ? bus_io.mem_rdata : '0;
  assign bus_io.if_stall  = bus_io.if_req && !ifAck;
  assign bus_io.d_ack     = dAck;
  assign bus_io.d_rdata   = dAck ? bus_io.mem_rdata : '0;
  assign bus_io.d_stall   = bus_io.d_req && !dAck;

  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_wstrb = mem_wstrb_q;
  assign bus_io.owner     = owner_q;
  assign bus_io.busy      = (state_q != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage pipeline. It sequences one outstanding transaction at a time, drives the per-requester stall outputs that feed `pc_stall`/`mem_stall`, and discards fetch responses killed by a branch/jump redirect. A streak counter prevents data traffic from starving instruction fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte strobes are `DATA_W/8`)
- `STARVE_LIMIT`, 4, consecutive contested data grants before fetch is forced (range 1..15)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request, held with `if_addr` stable until `if_ack` or `if_kill`
- `if_addr`  in  ADDR_W  fetch address
- `if_kill`  in  1  pulse: abandon the current/pending fetch (pipeline flush)
- `if_ack`  out  1  one-cycle pulse, fetch data valid
- `if_rdata`  out  DATA_W  fetch data, valid with `if_ack`
- `if_stall`  out  1  `if_req && !if_ack`
- `d_req`  in  1  data request, held with attributes stable until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  store byte enables
- `d_ack`  out  1  one-cycle pulse, access complete
- `d_rdata`  out  DATA_W  load data, valid with `d_ack`
- `d_stall`  out  1  `d_req && !d_ack`
- `mem_req`  out  1  memory request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered attributes
- `mem_gnt`  in  1  memory accepts request this cycle (`mem_req && mem_gnt`)
- `mem_rvalid`  in  1  response for the accepted request (loads and stores)
- `mem_rdata`  in  DATA_W  response data
- `owner`  out  1  0 = fetch, 1 = data; owner of the transaction in flight
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ (mem_req high, waiting `mem_gnt`), RESP (waiting `mem_rvalid`).
- IDLE: if any request is pending, choose owner, register attributes into `mem_*`, set `mem_req`, go REQ. Fetch registers `mem_we=0`, `mem_wstrb=0`, `mem_wdata=0`.
- Priority: data over fetch, unless `streak == STARVE_LIMIT` and both pending, then fetch.
- `streak` (4 bits): on an IDLE decision granting data while `if_req` is high, increments (saturates at STARVE_LIMIT); granting fetch clears it; decisions with only `d_req` leave it unchanged.
- REQ: `mem_*` held constant; on `mem_gnt` clear `mem_req`, go RESP.
- RESP: on `mem_rvalid` go IDLE; combinationally pulse `if_ack`/`d_ack` per `owner`; `if_rdata`/`d_rdata` = `mem_rdata` passthrough (0 when no ack).
- Kill: `if_kill` in any cycle with owner=fetch and state REQ/RESP sets `killed`; the transaction completes on the bus normally, `if_ack` is suppressed, `killed` clears on return to IDLE. `if_kill` in IDLE cancels nothing (requester drops `if_req` itself). `if_kill` coinciding with `mem_rvalid` suppresses that ack.
- A stall never depends on the other requester's ack.

## Timing
- Reset values: state IDLE, `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`/`mem_wstrb`=0, `owner`=0, `streak`=0, `killed`=0; hence all acks 0, `busy`=0.
- Reset asserted mid-transaction: immediate return to IDLE; in-flight response ignored; no ack.
- Minimum latency: request seen cycle 0 → `mem_req` cycle 1 (gnt same cycle) → `mem_rvalid` cycle 2 → ack cycle 2 → IDLE cycle 3, next decision cycle 3.
- Requesters change `if_req`/`d_req` only after the ack edge; arbiter samples them in IDLE only.
- `mem_rvalid` in IDLE/REQ is a protocol error: ignored, no ack.

## Test plan
- Single fetch: `if_req`, `if_addr=0x100` cycle 0; gnt cycle 1, rvalid+`mem_rdata=0x00000013` cycle 2 → `mem_req` only cycle 1, `mem_addr=0x100`, `mem_we=0`, `if_ack` cycle 2, `if_rdata=0x13`, `if_stall` 1 for cycles 0–1.
- Contention: `if_req` and `d_req` (store 0x200, data 0xDEADBEEF, strb 0xF) both cycle 0 → data transaction first, `owner=1`, `mem_wstrb=0xF`; fetch issued cycle 3 after `d_ack`.
- Starvation, `STARVE_LIMIT=4`: `d_req` reasserted continuously, `if_req` held → four data grants, fifth transaction is fetch, `streak` back to 0, then data again.
- Delayed grant: `mem_gnt` low 3 cycles → `mem_req` and all `mem_*` stable across cycles 1–4, RESP only after gnt.
- Kill: fetch in RESP, `if_kill` pulse, rvalid 2 cycles later → no `if_ack`, `busy` falls, following `d_req` granted normally.
- Reset mid-RESP: `rst` pulse while `busy=1` → outputs at reset values immediately; a late `mem_rvalid` produces no ack.
